grf_wb_arbiter: RTL and testbench

Shares the general register file's single write port between the in-order pipeline write-back stage and the long-latency auxiliary unit (multiply/divide, coprocessor results). Tracks which registers have an auxiliary result outstanding and reports that to the hazard logic. Drives the register file's write address, data and debug PC. A write address of 0 means "no write".

---
 rtl/grf_pkg.sv | 23 ++
 rtl/grf_scoreboard.sv | 31 +++
 rtl/grf_wb_arbiter.sv | 103 ++++++++++
 tb/tb_grf_wb_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/grf_pkg.sv
// Shared register-file types and constants for the write-back arbiter and its scoreboard.
package grf_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     word_t;

  localparam reg_addr_t REG_ZERO = '0;

  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
    word_t     data;
    word_t     pc;
  } wb_req_t;

  // A request targeting register 0 is a null request and never occupies the port.
  function automatic logic is_real(wb_req_t r);
    return r.valid && (r.addr != REG_ZERO);
  endfunction
endpackage

// File: rtl/grf_scoreboard.sv
// Pending-result scoreboard: one bit per register, set on long-latency issue,
// cleared on auxiliary write-back; set wins on collision. Register 0 never pends.
module grf_scoreboard
  import grf_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  reg_addr_t chk_addr1,
  input  reg_addr_t chk_addr2,
  output logic      chk_busy1,
  output logic      chk_busy2
);
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] set_mask, clr_mask;

  assign set_mask = {{(NUM_REGS-1){1'b0}}, set_en} << set_addr;
  assign clr_mask = {{(NUM_REGS-1){1'b0}}, clr_en} << clr_addr;

  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= ((pending & ~clr_mask) | set_mask) & {{(NUM_REGS-1){1'b1}}, 1'b0};
  end

  // Deliberately not bypassed: same-cycle issue/completion shows up next cycle.
  assign chk_busy1 = pending[chk_addr1];
  assign chk_busy2 = pending[chk_addr2];
endmodule

// File: rtl/grf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline priority, aged auxiliary force-grant,
// pending-result scoreboard. Optional trace/protocol checks under GRF_WB_TRACE_EN.
module grf_wb_arbiter
  import grf_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      pipe_valid,
  output logic      pipe_ready,
  input  reg_addr_t pipe_addr,
  input  word_t     pipe_data,
  input  word_t     pipe_pc,
  input  logic      aux_valid,
  output logic      aux_ready,
  input  reg_addr_t aux_addr,
  input  word_t     aux_data,
  input  word_t     aux_pc,
  input  logic      iss_valid,
  input  reg_addr_t iss_addr,
  input  reg_addr_t chk_addr1,
  input  reg_addr_t chk_addr2,
  output logic      chk_busy1,
  output logic      chk_busy2,
  output reg_addr_t wr_addr,
  output word_t     wr_data,
  output word_t     wr_pc
);
  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  wb_req_t    pipe_req, aux_req;
  logic       pipe_real, aux_real;
  logic       aux_win, pipe_win;
  logic [3:0] wait_cnt;

  assign pipe_req  = '{valid: pipe_valid, addr: pipe_addr, data: pipe_data, pc: pipe_pc};
  assign aux_req   = '{valid: aux_valid,  addr: aux_addr,  data: aux_data,  pc: aux_pc};
  assign pipe_real = is_real(pipe_req);
  assign aux_real  = is_real(aux_req);

  always_comb begin
    aux_win    = 1'b0;
    pipe_win   = 1'b0;
    pipe_ready = 1'b0;
    aux_ready  = 1'b0;
    wr_addr    = REG_ZERO;
    wr_data    = '0;
    wr_pc      = '0;
    if (!reset) begin
      aux_win    = aux_real && (!pipe_real || wait_cnt == WAIT_LIM);
      pipe_win   = pipe_real && !aux_win;
      pipe_ready = !(pipe_real && aux_win);
      aux_ready  = !aux_real || aux_win;
      if (aux_win) begin
        wr_addr = aux_req.addr;
        wr_data = aux_req.data;
        wr_pc   = aux_req.pc;
      end else if (pipe_win) begin
        wr_addr = pipe_req.addr;
        wr_data = pipe_req.data;
        wr_pc   = pipe_req.pc;
      end
    end
  end

  // Counts consecutive lost cycles of a real aux request; any acceptance or drop restarts it.
  always_ff @(posedge clk) begin
    if (reset)                         wait_cnt <= '0;
    else if (aux_real && !aux_ready) begin
      if (wait_cnt != WAIT_LIM)        wait_cnt <= wait_cnt + 4'd1;
    end else                           wait_cnt <= '0;
  end

  grf_scoreboard u_sb (
    .clk       (clk),
    .reset     (reset),
    .set_en    (iss_valid && (iss_addr != REG_ZERO)),
    .set_addr  (iss_addr),
    .clr_en    (aux_win),
    .clr_addr  (aux_addr),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .chk_busy1 (chk_busy1),
    .chk_busy2 (chk_busy2)
  );

`ifdef GRF_WB_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wr_addr != REG_ZERO)
        $display("@%h: $%0d <= %h", wr_pc, wr_addr, wr_data);
      if (iss_valid && iss_addr != REG_ZERO && u_sb.pending[iss_addr]
          && !(aux_win && aux_addr == iss_addr))
        $display("ERROR: issue to pending register $%0d", iss_addr);
      if (pipe_win && u_sb.pending[pipe_addr])
        $display("ERROR: pipeline write to pending register $%0d", pipe_addr);
      if (aux_win && !u_sb.pending[aux_addr])
        $display("ERROR: auxiliary write to non-pending register $%0d", aux_addr);
    end
  end
`endif
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Self-checking bench for grf_wb_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural model of the arbitration and scoreboard rules.
module tb_grf_wb_arbiter;
  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_valid, pipe_ready;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data, pipe_pc;
  logic        aux_valid, aux_ready;
  logic [4:0]  aux_addr;
  logic [31:0] aux_data, aux_pc;
  logic        iss_valid;
  logic [4:0]  iss_addr, chk_addr1, chk_addr2;
  logic        chk_busy1, chk_busy2;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data, wr_pc;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_lost;
  bit m_pend [32];
  bit e_pr, e_ar, e_b1, e_b2, e_auxgets;
  logic [4:0]  e_wa;
  logic [31:0] e_wd, e_wp;

  always #5 clk = ~clk;

  grf_wb_arbiter #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_ready(pipe_ready), .pipe_addr(pipe_addr),
    .pipe_data(pipe_data), .pipe_pc(pipe_pc),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_addr(aux_addr),
    .aux_data(aux_data), .aux_pc(aux_pc),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_pc(wr_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; pipe_valid = 0; pipe_addr = 0; pipe_data = 0; pipe_pc = 0;
    aux_valid = 0; aux_addr = 0; aux_data = 0; aux_pc = 0;
    iss_valid = 0; iss_addr = 0; chk_addr1 = 0; chk_addr2 = 0;
  endtask

  // Expected outputs from the rules: pipeline first unless aux has lost MAXW times.
  task automatic model_eval();
    bit p_real, a_real;
    p_real = pipe_valid && pipe_addr != 0;
    a_real = aux_valid && aux_addr != 0;
    e_b1 = m_pend[chk_addr1];
    e_b2 = m_pend[chk_addr2];
    e_auxgets = 0; e_pr = 0; e_ar = 0; e_wa = 0; e_wd = 0; e_wp = 0;
    if (!reset) begin
      e_auxgets = a_real && (!p_real || m_lost >= MAXW);
      e_pr = !(p_real && e_auxgets);
      e_ar = !a_real || e_auxgets;
      if (e_auxgets) begin e_wa = aux_addr; e_wd = aux_data; e_wp = aux_pc; end
      else if (p_real) begin e_wa = pipe_addr; e_wd = pipe_data; e_wp = pipe_pc; end
    end
  endtask

  task automatic model_commit();
    model_eval();
    if (reset) begin
      m_lost = 0;
      foreach (m_pend[i]) m_pend[i] = 0;
    end else begin
      if (aux_valid && aux_addr != 0 && !e_auxgets) m_lost = (m_lost + 1 > MAXW) ? MAXW : m_lost + 1;
      else m_lost = 0;
      if (e_auxgets) m_pend[aux_addr] = 0;
      if (iss_valid && iss_addr != 0) m_pend[iss_addr] = 1;
    end
  endtask

  task automatic test_reset();
    idle(); reset = 1;
    pipe_valid = 1; pipe_addr = 8; pipe_data = 32'hdead; pipe_pc = 32'h40;
    aux_valid = 1; aux_addr = 5; aux_data = 32'hbeef; aux_pc = 32'h44;
    #1;
    checks++; if (pipe_ready !== 1'b0) begin errors++; $display("FAIL reset_pipe_ready got=%b exp=0", pipe_ready); end
    checks++; if (aux_ready !== 1'b0) begin errors++; $display("FAIL reset_aux_ready got=%b exp=0", aux_ready); end
    checks++; if (wr_addr !== 5'd0 || wr_data !== 32'd0 || wr_pc !== 32'd0) begin
      errors++; $display("FAIL reset_wr got=%0d/%h/%h exp=0/0/0", wr_addr, wr_data, wr_pc); end
    tick(); tick();
    idle(); chk_addr1 = 3; chk_addr2 = 31; #1;
    checks++; if (chk_busy1 !== 1'b0 || chk_busy2 !== 1'b0) begin
      errors++; $display("FAIL reset_busy got=%b%b exp=00", chk_busy1, chk_busy2); end
  endtask

  task automatic test_pipe_only();
    idle(); pipe_valid = 1; pipe_addr = 8; pipe_data = 32'h1234; pipe_pc = 32'h100; #1;
    checks++; if (pipe_ready !== 1'b1) begin errors++; $display("FAIL pipe_only_ready got=%b exp=1", pipe_ready); end
    checks++; if (wr_addr !== 5'd8 || wr_data !== 32'h1234 || wr_pc !== 32'h100) begin
      errors++; $display("FAIL pipe_only_wr got=%0d/%h/%h exp=8/1234/100", wr_addr, wr_data, wr_pc); end
    tick(); idle();
  endtask

  task automatic test_contention(input string tag);
    idle();
    pipe_valid = 1; pipe_addr = 9; pipe_data = 32'h99; pipe_pc = 32'h200;
    aux_valid = 1; aux_addr = 2; aux_data = 32'haa; aux_pc = 32'h300;
    for (int c = 0; c <= MAXW; c++) begin
      #1;
      checks++; if (aux_ready !== (c == MAXW) || pipe_ready !== (c != MAXW)) begin
        errors++; $display("FAIL %s_cyc%0d ready got=p%b a%b exp=p%b a%b", tag, c, pipe_ready, aux_ready, c != MAXW, c == MAXW); end
      checks++; if (wr_addr !== ((c == MAXW) ? 5'd2 : 5'd9)) begin
        errors++; $display("FAIL %s_cyc%0d wr_addr got=%0d exp=%0d", tag, c, wr_addr, (c == MAXW) ? 2 : 9); end
      tick();
    end
    aux_valid = 0; #1;
    checks++; if (pipe_ready !== 1'b1 || wr_addr !== 5'd9) begin
      errors++; $display("FAIL %s_resume got=p%b wa%0d exp=p1 wa9", tag, pipe_ready, wr_addr); end
    tick(); idle();
  endtask

  task automatic test_null();
    idle(); pipe_valid = 1; pipe_addr = 0; pipe_data = 32'h77;
    aux_valid = 1; aux_addr = 5; aux_data = 32'h55; aux_pc = 32'h500; #1;
    checks++; if (pipe_ready !== 1'b1 || aux_ready !== 1'b1) begin
      errors++; $display("FAIL null_pipe_ready got=p%b a%b exp=p1 a1", pipe_ready, aux_ready); end
    checks++; if (wr_addr !== 5'd5 || wr_data !== 32'h55) begin
      errors++; $display("FAIL null_pipe_wr got=%0d/%h exp=5/55", wr_addr, wr_data); end
    aux_addr = 0; #1;
    checks++; if (pipe_ready !== 1'b1 || aux_ready !== 1'b1 || wr_addr !== 5'd0) begin
      errors++; $display("FAIL both_null got=p%b a%b wa%0d exp=p1 a1 wa0", pipe_ready, aux_ready, wr_addr); end
    tick(); idle();
  endtask

  task automatic test_scoreboard();
    idle(); chk_addr1 = 3; chk_addr2 = 4; iss_valid = 1; iss_addr = 3; #1;
    checks++; if (chk_busy1 !== 1'b0) begin errors++; $display("FAIL sb_no_bypass got=%b exp=0", chk_busy1); end
    tick(); iss_valid = 0; #1;
    checks++; if (chk_busy1 !== 1'b1 || chk_busy2 !== 1'b0) begin
      errors++; $display("FAIL sb_set got=%b%b exp=10", chk_busy1, chk_busy2); end
    aux_valid = 1; aux_addr = 3; aux_data = 32'h33; #1;
    checks++; if (aux_ready !== 1'b1 || chk_busy1 !== 1'b1) begin
      errors++; $display("FAIL sb_complete_same got=a%b b%b exp=a1 b1", aux_ready, chk_busy1); end
    tick(); aux_valid = 0; #1;
    checks++; if (chk_busy1 !== 1'b0) begin errors++; $display("FAIL sb_clear got=%b exp=0", chk_busy1); end
    iss_valid = 1; tick(); iss_valid = 1; aux_valid = 1; tick(); iss_valid = 0; aux_valid = 0; #1;
    checks++; if (chk_busy1 !== 1'b1) begin errors++; $display("FAIL sb_set_wins got=%b exp=1", chk_busy1); end
    aux_valid = 1; tick(); idle(); chk_addr1 = 3; #1;
    checks++; if (chk_busy1 !== 1'b0) begin errors++; $display("FAIL sb_final_clear got=%b exp=0", chk_busy1); end
  endtask

  task automatic test_reset_mid();
    idle(); iss_valid = 1; iss_addr = 4; tick(); iss_addr = 7; tick(); idle();
    pipe_valid = 1; pipe_addr = 9; aux_valid = 1; aux_addr = 2;
    tick(); tick(); tick();
    reset = 1; iss_valid = 1; iss_addr = 12; #1;
    checks++; if (pipe_ready !== 1'b0 || aux_ready !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'd0 || wr_pc !== 32'd0) begin
      errors++; $display("FAIL mid_reset_outputs got=p%b a%b wa%0d exp=0", pipe_ready, aux_ready, wr_addr); end
    tick(); idle(); chk_addr1 = 4; chk_addr2 = 7; #1;
    checks++; if (chk_busy1 !== 1'b0 || chk_busy2 !== 1'b0) begin
      errors++; $display("FAIL mid_reset_pending got=%b%b exp=00", chk_busy1, chk_busy2); end
    chk_addr1 = 12; #1;
    checks++; if (chk_busy1 !== 1'b0) begin errors++; $display("FAIL mid_reset_issue got=%b exp=0", chk_busy1); end
    test_contention("post_reset");
  endtask

  task automatic test_random();
    bit hold;
    int pick;
    idle(); reset = 1; model_commit(); tick();
    hold = 0;
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      if (!hold) begin
        aux_valid = 0; aux_addr = 0;
        if ($urandom_range(0, 9) < 6) begin
          pick = $urandom_range(1, 31);
          for (int k = 0; k < 32; k++)
            if (m_pend[(pick + k) % 32] && ((pick + k) % 32) != 0) begin aux_valid = 1; aux_addr = 5'((pick + k) % 32); break; end
          if ($urandom_range(0, 9) == 0) begin aux_valid = 1; aux_addr = 0; end
        end
        aux_data = $urandom; aux_pc = $urandom;
      end
      pipe_valid = ($urandom_range(0, 9) < 7);
      pipe_addr = 5'($urandom_range(0, 31));
      if (m_pend[pipe_addr]) pipe_addr = 0;
      pipe_data = $urandom; pipe_pc = $urandom;
      iss_addr = 5'($urandom_range(1, 31));
      iss_valid = ($urandom_range(0, 3) == 0) && !m_pend[iss_addr] && !(aux_valid && aux_addr == iss_addr);
      chk_addr1 = 5'($urandom_range(0, 31)); chk_addr2 = 5'($urandom_range(0, 31));
      #1;
      model_eval();
      checks++; if (pipe_ready !== e_pr || aux_ready !== e_ar) begin
        errors++; $display("FAIL rand%0d ready got=p%b a%b exp=p%b a%b", n, pipe_ready, aux_ready, e_pr, e_ar); end
      checks++; if (wr_addr !== e_wa || wr_data !== e_wd || wr_pc !== e_wp) begin
        errors++; $display("FAIL rand%0d wr got=%0d/%h/%h exp=%0d/%h/%h", n, wr_addr, wr_data, wr_pc, e_wa, e_wd, e_wp); end
      checks++; if (chk_busy1 !== e_b1 || chk_busy2 !== e_b2) begin
        errors++; $display("FAIL rand%0d busy got=%b%b exp=%b%b", n, chk_busy1, chk_busy2, e_b1, e_b2); end
      hold = !reset && aux_valid && aux_addr != 0 && !e_ar;
      model_commit();
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    m_lost = 0;
    foreach (m_pend[i]) m_pend[i] = 0;
    test_reset();
    test_pipe_only();
    test_contention("contention");
    test_null();
    test_scoreboard();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
